sine_width_gen: RTL and testbench
=================================

Name: sine_width_gen

Overview:
- Upstream neighbour of the PWM comparator stage in the sine wave generator.
- On every PWM period tick it presents a new 32-bit duty width, 0..PERIOD, that traces one sine cycle.
- Uses a phase accumulator and a quarter-wave ROM with symmetry folding.
- The next width is precomputed during the current PWM period, so the comparator sees a stable width for the whole period.

Parameters:
- PERIOD, 1000, PWM period in clocks; must equal the tick counter MAX; full-scale width.
- PHASE_W, 32, phase accumulator width.
- LUT_AW, 6, quarter-wave index bits; ROM holds 2^LUT_AW+1 entries (index 0..2^LUT_AW inclusive).

Ports:
- clk  in  1  single system clock (PLL output domain).
- rst  in  1  reset, asynchronous, active-high.
- tick  in  1  one-cycle pulse at each PWM period boundary.
- enable  in  1  generator run; sampled on tick.
- phase_inc  in  PHASE_W  frequency tuning word; sampled on tick.
- width_sine  out  32  duty width to the comparator; changes only the cycle after an accepted tick.
- width_update  out  1  one-cycle pulse, coincident with width_sine taking its new value.
- overrun  out  1  sticky flag: a tick arrived before the next width was ready.

Behaviour:
- Reset (async, rst=1):
  - phase_acc=0; width_sine=PERIOD/2; next_width=PERIOD/2; ready=1; width_update=0; overrun=0; pipeline valid bits=0.
- ROM:
  - amp[k] = round((PERIOD/2)*sin(pi/2*k/2^LUT_AW)), k=0..2^LUT_AW.
  - amp[0]=0, amp[2^LUT_AW]=PERIOD/2.
- Phase decode, taken from phase_acc:
  - q = phase_acc[PHASE_W-1:PHASE_W-2].
  - idx = the LUT_AW bits directly below q.
  - Lower bits are truncated; no interpolation.
- Fold rules:
  - q=0: PERIOD/2 + amp[idx].
  - q=1: PERIOD/2 + amp[2^LUT_AW - idx].
  - q=2: PERIOD/2 - amp[idx].
  - q=3: PERIOD/2 - amp[2^LUT_AW - idx].
  - Result clamped to [0, PERIOD] and zero-extended to 32 bits.
- Tick accepted with enable=1 and ready=1:
  - Next edge: width_sine<=next_width, width_update=1, phase_acc<=phase_acc+phase_inc (mod 2^PHASE_W), ready<=0.
- Pipeline after an accepted tick:
  - Stage 1 (edge T+1): phase_acc updated.
  - Stage 2 (T+2): ROM address and quadrant registered.
  - Stage 3 (T+3): amp registered.
  - Stage 4 (T+4): folded and clamped result written to next_width, ready<=1.
  - ready is therefore 1 at least 4 cycles after each accepted tick.
- tick with enable=1 and ready=0:
  - width_sine is not changed; width_update=0; phase is not advanced; the in-flight computation continues; overrun<=1 (sticky until rst).
- tick with enable=0:
  - width_sine<=PERIOD/2; width_update=1; phase_acc is held; next_width is held.
  - When enable returns, the next tick resumes from the held phase.
- No tick: all outputs hold; width_update=0.
- phase_inc=0 with enable=1: width_sine repeats the same value on every tick.
- Reset mid-pipeline: all in-flight data is discarded and the block returns to reset values immediately.

Test Plan:
- Release rst; phase_inc=2^24 (idx +1 per tick); enable=1; tick every 1000 clocks.
  - Width at tick n = f(phase (n-1)*2^24): tick1=500, tick33=854, tick65=1000, tick129=500, tick193=0, tick257=500 (wrap).
  - width_update pulses exactly once per tick.
- Same setup, check every width value:
  - Widths never exceed 1000.
  - Sequence symmetric: width(tick 65+k) = width(tick 65-k) for k=1..63.
- Two ticks spaced 2 clocks after an accepted tick:
  - Second tick ignored; width_sine unchanged; overrun=1 and stays 1 through later normal ticks until rst.
- enable=0 for 3 ticks mid-sweep at phase idx 10:
  - Each tick gives width 500.
  - Re-enable: next tick outputs the idx-10 value, i.e. the sweep continues without skipping.
- Assert rst 2 clocks after a tick at width 854:
  - width_sine=500, overrun=0, width_update=0 immediately (async).
  - After release, first tick outputs 500.
- phase_inc=2^30 (quarter cycle per tick):
  - Successive tick widths 500, 1000, 500, 0, 500, repeating.

Source files
------------

// File: rtl/sine_width_gen_if.sv
// Control/result bundle between the PWM tick source, the width generator and the comparator.
interface sine_width_gen_if #(
  parameter int PHASE_W = 32
);
  logic               tick;
  logic               enable;
  logic [PHASE_W-1:0] phase_inc;
  logic [31:0]        width_sine;
  logic               width_update;
  logic               overrun;

  modport master (
    output tick, enable, phase_inc,
    input  width_sine, width_update, overrun
  );

  modport slave (
    input  tick, enable, phase_inc,
    output width_sine, width_update, overrun
  );
endinterface

// File: rtl/sine_width_gen.sv
// Sine duty-width source: phase accumulator + folded quarter-wave ROM, new width one cycle after each tick.
// Next width is precomputed over 4 cycles; a tick arriving before it is ready is dropped and flagged sticky overrun.
module sine_width_gen #(
  parameter int PERIOD  = 1000,
  parameter int PHASE_W = 32,
  parameter int LUT_AW  = 6
) (
  input logic             clk,
  input logic             rst,
  sine_width_gen_if.slave bus
);

  localparam int                 LUT_N   = 1 << LUT_AW;
  localparam logic [31:0]        HALF    = 32'(PERIOD / 2);
  localparam logic [31:0]        FULL    = 32'(PERIOD);
  localparam logic signed [33:0] HALF_S  = 34'(PERIOD / 2);
  localparam logic signed [33:0] FULL_S  = 34'(PERIOD);
  localparam logic [LUT_AW:0]    LUT_N_A = (LUT_AW + 1)'(LUT_N);

  // Elaboration-time sine via Taylor series; the table is pure constants after synthesis.
  function automatic logic [31:0] amp_calc(input int k);
    real x;
    real term;
    real sum;
    x    = 1.5707963267948966 * real'(k) / real'(LUT_N);
    term = x;
    sum  = x;
    for (int n = 1; n <= 10; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    return 32'($rtoi(real'(PERIOD / 2) * sum + 0.5));
  endfunction

  logic [31:0] rom [0:LUT_N];

  for (genvar k = 0; k <= LUT_N; k++) begin : g_rom
    localparam logic [31:0] AMP_K = amp_calc(k);
    assign rom[k] = AMP_K;
  end

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [31:0]        width_q, width_d;
  logic [31:0]        next_q, next_d;
  logic               ready_q, ready_d;
  logic               upd_q, upd_d;
  logic               ovr_q, ovr_d;
  logic               s1_vld_q, s1_vld_d;
  logic               s2_vld_q, s2_vld_d;
  logic               s3_vld_q, s3_vld_d;
  logic [LUT_AW:0]    addr2_q, addr2_d;
  logic               neg2_q, neg2_d;
  logic [31:0]        amp3_q, amp3_d;
  logic               neg3_q, neg3_d;

  logic [LUT_AW-1:0]  idx;
  logic signed [33:0] fold_s;
  logic [31:0]        clamp;

  always_comb begin
    phase_d  = phase_q;
    width_d  = width_q;
    next_d   = next_q;
    ready_d  = ready_q;
    upd_d    = 1'b0;
    ovr_d    = ovr_q;
    s1_vld_d = 1'b0;
    s2_vld_d = s1_vld_q;
    s3_vld_d = s2_vld_q;
    addr2_d  = addr2_q;
    neg2_d   = neg2_q;
    amp3_d   = amp3_q;
    neg3_d   = neg3_q;

    idx    = phase_q[PHASE_W-3 -: LUT_AW];
    fold_s = neg3_q ? (HALF_S - $signed({2'b00, amp3_q}))
                    : (HALF_S + $signed({2'b00, amp3_q}));
    if (fold_s < 34'sd0) begin
      clamp = '0;
    end else if (fold_s > FULL_S) begin
      clamp = FULL;
    end else begin
      clamp = fold_s[31:0];
    end

    if (bus.tick) begin
      if (!bus.enable) begin
        width_d = HALF;
        upd_d   = 1'b1;
      end else if (ready_q) begin
        width_d  = next_q;
        upd_d    = 1'b1;
        phase_d  = phase_q + bus.phase_inc;
        ready_d  = 1'b0;
        s1_vld_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end

    // Odd quadrants walk the quarter table backwards; quadrants 2-3 are below mid-scale.
    if (s1_vld_q) begin
      addr2_d = phase_q[PHASE_W-2] ? (LUT_N_A - {1'b0, idx}) : {1'b0, idx};
      neg2_d  = phase_q[PHASE_W-1];
    end
    if (s2_vld_q) begin
      amp3_d = rom[addr2_q];
      neg3_d = neg2_q;
    end
    if (s3_vld_q) begin
      next_d  = clamp;
      ready_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q  <= '0;
      width_q  <= HALF;
      next_q   <= HALF;
      ready_q  <= 1'b1;
      upd_q    <= 1'b0;
      ovr_q    <= 1'b0;
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      s3_vld_q <= 1'b0;
      addr2_q  <= '0;
      neg2_q   <= 1'b0;
      amp3_q   <= '0;
      neg3_q   <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      width_q  <= width_d;
      next_q   <= next_d;
      ready_q  <= ready_d;
      upd_q    <= upd_d;
      ovr_q    <= ovr_d;
      s1_vld_q <= s1_vld_d;
      s2_vld_q <= s2_vld_d;
      s3_vld_q <= s3_vld_d;
      addr2_q  <= addr2_d;
      neg2_q   <= neg2_d;
      amp3_q   <= amp3_d;
      neg3_q   <= neg3_d;
    end
  end

  assign bus.width_sine   = width_q;
  assign bus.width_update = upd_q;
  assign bus.overrun      = ovr_q;

endmodule

// File: tb/tb_sine_width_gen.sv
// Scoreboard bench for sine_width_gen: driver queues expected widths, negedge monitor pops on width_update.
module tb_sine_width_gen;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sine_width_gen_if #(.PHASE_W(32)) bus_if ();

  sine_width_gen #(
    .PERIOD (1000),
    .PHASE_W(32),
    .LUT_AW (6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  int          n_chk  = 0;
  int          n_fail = 0;
  int          exp_q[$];
  int          got[$];
  logic [31:0] m_phase;
  int          m_next;
  int          last_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference width using the simulator's own $sin, independent of the RTL table.
  function automatic int ref_width(input logic [31:0] ph);
    int q;
    int idx;
    int a;
    q   = int'(ph[31:30]);
    idx = int'(ph[29:24]);
    if (q == 1 || q == 3) idx = 64 - idx;
    a = $rtoi(500.0 * $sin(3.141592653589793 * real'(idx) / 128.0) + 0.5);
    return (q < 2) ? 500 + a : 500 - a;
  endfunction

  always @(negedge clk) begin
    if (rst === 1'b0 && bus_if.width_update === 1'b1) begin
      got.push_back(int'(bus_if.width_sine));
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL spurious_update: width_update with no tick pending, width %0d", bus_if.width_sine);
      end else begin
        check("width", 64'(bus_if.width_sine), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic tick_once(input bit acc);
    if (!bus_if.enable) begin
      exp_q.push_back(500);
    end else if (acc) begin
      exp_q.push_back(m_next);
      last_exp = m_next;
      m_phase  = m_phase + bus_if.phase_inc;
      m_next   = ref_width(m_phase);
    end
    @(posedge clk); #1 bus_if.tick = 1'b1;
    @(posedge clk); #1 bus_if.tick = 1'b0;
  endtask

  task automatic sweep(input int n);
    repeat (n) begin
      tick_once(1'b1);
      idle(6);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus_if.tick = 1'b0;
    idle(3);
    #1;
    check("queue_drained", 64'(exp_q.size()), 0);
    exp_q.delete();
    m_phase = '0;
    m_next  = 500;
    check("rst_width", 64'(bus_if.width_sine), 500);
    check("rst_update", 64'(bus_if.width_update), 0);
    check("rst_overrun", 64'(bus_if.overrun), 0);
    @(posedge clk); #1 rst = 1'b0;
    idle(2);
  endtask

  initial begin
    int hand [12];
    int viol;
    rst              = 1'b1;
    bus_if.tick      = 1'b0;
    bus_if.enable    = 1'b0;
    bus_if.phase_inc = '0;
    m_phase          = '0;
    m_next           = 500;
    last_exp         = 500;
    do_reset();

    // Full cycle sweep, one index step per tick.
    bus_if.enable    = 1'b1;
    bus_if.phase_inc = 32'h0100_0000;
    got.delete();
    sweep(257);
    idle(4);
    if (got.size() < 257) begin
      check("sweep_len", 64'(got.size()), 257);
    end else begin
      check("tick1", 64'(got[0]), 500);
      check("tick33", 64'(got[32]), 854);
      check("tick65", 64'(got[64]), 1000);
      check("tick129", 64'(got[128]), 500);
      check("tick193", 64'(got[192]), 0);
      check("tick257", 64'(got[256]), 500);
      viol = 0;
      foreach (got[i]) if (got[i] > 1000) viol++;
      check("max_1000", 64'(viol), 0);
      for (int k = 1; k <= 63; k++) check("symmetry", 64'(got[64 + k]), 64'(got[64 - k]));
    end

    // Disable for three ticks at idx 10, then resume without skipping.
    do_reset();
    bus_if.enable    = 1'b1;
    bus_if.phase_inc = 32'h0100_0000;
    sweep(10);
    bus_if.enable = 1'b0;
    sweep(3);
    check("disabled_width", 64'(bus_if.width_sine), 500);
    bus_if.enable = 1'b1;
    sweep(1);
    check("resume_idx10", 64'(bus_if.width_sine), 621);
    sweep(1);

    // Tick two clocks after an accepted tick is dropped; overrun sticks.
    tick_once(1'b1);
    tick_once(1'b0);
    idle(1);
    #1;
    check("ovr_hold_width", 64'(bus_if.width_sine), 64'(last_exp));
    check("ovr_set", 64'(bus_if.overrun), 1);
    idle(8);
    sweep(2);
    check("ovr_sticky", 64'(bus_if.overrun), 1);

    // Async reset in the middle of a computation.
    do_reset();
    bus_if.enable    = 1'b1;
    bus_if.phase_inc = 32'h0100_0000;
    sweep(32);
    tick_once(1'b1);
    tick_once(1'b0);
    check("pre_rst_width", 64'(bus_if.width_sine), 854);
    check("pre_rst_overrun", 64'(bus_if.overrun), 1);
    rst = 1'b1;
    #1;
    check("async_width", 64'(bus_if.width_sine), 500);
    check("async_overrun", 64'(bus_if.overrun), 0);
    check("async_update", 64'(bus_if.width_update), 0);
    do_reset();
    sweep(1);
    check("post_rst_first", 64'(bus_if.width_sine), 500);

    // Quarter cycle per tick, then a zero tuning word holds the value.
    do_reset();
    bus_if.phase_inc = 32'h4000_0000;
    got.delete();
    sweep(9);
    bus_if.phase_inc = '0;
    sweep(3);
    idle(4);
    hand = '{500, 1000, 500, 0, 500, 1000, 500, 0, 500, 1000, 1000, 1000};
    if (got.size() != 12) begin
      check("quarter_len", 64'(got.size()), 12);
    end else begin
      for (int i = 0; i < 12; i++) check("quarter_seq", 64'(got[i]), 64'(hand[i]));
    end

    idle(5);
    check("scoreboard_empty", 64'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
